// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: scheduler state type, digit count and the
// hex glyph decoder used by every display user on the board.
package seg7_pkg;

  typedef enum logic [0:0] {S_IDLE, S_OWN} sched_state_t;

  localparam int unsigned NUM_DIGITS = 8;

  // 4-bit code to active-low {DP,CG,CF,CE,CD,CC,CB,CA}; DP always off.
  function automatic logic [7:0] seg7_glyph(input logic [3:0] code);
    logic [7:0] pat;
    case (code)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = 8'h88;
      4'hB:    pat = 8'h83;
      4'hC:    pat = 8'hC6;
      4'hD:    pat = 8'hA1;
      4'hE:    pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_display_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request after owner_i,
// wrapping, with owner_i itself examined last.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    owner_i,
  output logic               found_o,
  output logic [IdxW-1:0]    next_o
);

  logic [IdxW:0] sum;

  always_comb begin
    found_o = 1'b0;
    next_o  = '0;
    sum     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      sum = {1'b0, owner_i} + (IdxW+1)'(k);
      // owner_i < NUM_REQ and k <= NUM_REQ, so one subtraction wraps it
      if (sum >= (IdxW+1)'(NUM_REQ)) begin
        sum = sum - (IdxW+1)'(NUM_REQ);
      end
      if (!found_o && req_i[sum[IdxW-1:0]]) begin
        found_o = 1'b1;
        next_o  = sum[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Time-shares an 8-digit common-anode display among NUM_REQ requesters with
// frame-aligned round-robin grants, per-frame snapshots and guarded digit scan.
module seg7_display_scheduler
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned GUARD_CYC   = 200,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic                 CLK100MHZ,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*32-1:0] digits,
  input  logic [NUM_REQ*8-1:0] blank,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 frame_tick,
  output logic [7:0]           AN,
  output logic                 CA,
  output logic                 CB,
  output logic                 CC,
  output logic                 CD,
  output logic                 CE,
  output logic                 CF,
  output logic                 CG,
  output logic                 DP
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned FcW   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [SlotW-1:0] slot_q, slot_d;
  logic [2:0]       idx_q, idx_d;
  logic             slot_tc;

  sched_state_t     state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IdxW-1:0]  owner_q;
  logic [FcW-1:0]   fc_q;
  logic [31:0]      dig_snap_q;
  logic [7:0]       blank_snap_q;

  logic [IdxW-1:0]  pick_base, pick_idx, sel_idx;
  logic             pick_found, hold;
  logic [31:0]      sel_dig;
  logic [7:0]       sel_blank;

  logic             an_off;
  logic [3:0]       nib;
  logic [7:0]       seg;

  // Scan counters
  always_comb begin
    slot_tc    = (slot_q == SlotW'(SCAN_DIV - 1));
    slot_d     = slot_tc ? '0 : slot_q + 1'b1;
    idx_d      = slot_tc ? idx_q + 3'd1 : idx_q;
    frame_tick = slot_tc && (idx_q == 3'(NUM_DIGITS - 1));
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  // From idle, starting the search after the top index yields the lowest set request.
  assign pick_base = (state_q == S_IDLE) ? IdxW'(NUM_REQ - 1) : owner_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req),
    .owner_i (pick_base),
    .found_o (pick_found),
    .next_o  (pick_idx)
  );

  always_comb begin
    hold      = (state_q == S_OWN) && req[owner_q] && (fc_q < FcW'(HOLD_FRAMES - 1));
    sel_idx   = hold ? owner_q : pick_idx;
    sel_dig   = '0;
    sel_blank = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_idx == IdxW'(i)) begin
        sel_dig   = digits[i*32 +: 32];
        sel_blank = blank[i*8 +: 8];
      end
    end
  end

  // Arbitration FSM; everything it owns changes only at a frame boundary.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      fc_q         <= '0;
      dig_snap_q   <= '0;
      blank_snap_q <= '0;
    end else if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            state_q      <= S_OWN;
            owner_q      <= pick_idx;
            gnt_q        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            fc_q         <= '0;
            dig_snap_q   <= sel_dig;
            blank_snap_q <= sel_blank;
          end
        end
        S_OWN: begin
          if (hold) begin
            fc_q         <= fc_q + 1'b1;
            dig_snap_q   <= sel_dig;
            blank_snap_q <= sel_blank;
          end else if (pick_found) begin
            owner_q      <= pick_idx;
            gnt_q        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            fc_q         <= '0;
            dig_snap_q   <= sel_dig;
            blank_snap_q <= sel_blank;
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            fc_q    <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt = gnt_q;

  always_comb begin
    an_off = (slot_q < SlotW'(GUARD_CYC)) || (state_q == S_IDLE) || blank_snap_q[idx_q];
    AN     = an_off ? 8'hFF : ~(8'd1 << idx_q);
    nib    = dig_snap_q[{idx_q, 2'b00} +: 4];
    seg    = an_off ? 8'hFF : seg7_glyph(nib);
    {DP, CG, CF, CE, CD, CC, CB, CA} = seg;
  end

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Self-checking bench: per-cycle reference model plus directed frame scenarios.
module tb_seg7_display_scheduler;

  localparam int NR = 3, SD = 8, GC = 2, HF = 2, FRAME = 64;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req;
  logic [NR*32-1:0] digits;
  logic [NR*8-1:0]  blank;
  logic [NR-1:0]    gnt;
  logic             frame_tick;
  logic [7:0]       an;
  logic ca, cb, cc, cd, ce, cf, cg, dp;
  logic [7:0]       seg_act;

  assign seg_act = {dp, cg, cf, ce, cd, cc, cb, ca};

  always #5 clk = ~clk;

  seg7_display_scheduler #(
    .NUM_REQ     (NR),
    .SCAN_DIV    (SD),
    .GUARD_CYC   (GC),
    .HOLD_FRAMES (HF)
  ) dut (
    .CLK100MHZ  (clk),
    .RST        (rst),
    .req        (req),
    .digits     (digits),
    .blank      (blank),
    .gnt        (gnt),
    .frame_tick (frame_tick),
    .AN         (an),
    .CA         (ca),
    .CB         (cb),
    .CC         (cc),
    .CD         (cd),
    .CE         (ce),
    .CF         (cf),
    .CG         (cg),
    .DP         (dp)
  );

  typedef struct {
    logic [3:0] code;
    logic [7:0] seg;
  } glyph_vec_t;

  glyph_vec_t gvec[16];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the frame, owner (-1 idle), hold count, snapshot
  int          m_t, m_own, m_fc;
  logic [31:0] m_dig;
  logic [7:0]  m_blank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_t = 0; m_own = -1; m_fc = 0; m_dig = '0; m_blank = '0;
  endfunction

  function automatic void model_load(input int c);
    m_dig   = digits[32*c +: 32];
    m_blank = blank[8*c +: 8];
  endfunction

  function automatic void model_step();
    int pick, start;
    if (m_t == FRAME - 1) begin
      if (m_own >= 0 && req[m_own] && m_fc < HF - 1) begin
        m_fc++;
        model_load(m_own);
      end else begin
        pick  = -1;
        start = (m_own < 0) ? 0 : m_own + 1;
        for (int k = 0; k < NR; k++)
          if (pick < 0 && req[(start + k) % NR]) pick = (start + k) % NR;
        if (pick >= 0) begin
          m_own = pick; m_fc = 0;
          model_load(pick);
        end else begin
          m_own = -1; m_fc = 0;
        end
      end
    end
    m_t = (m_t + 1) % FRAME;
  endfunction

  task automatic compare_all();
    int slot, idx;
    logic [7:0] exp_an, exp_seg;
    logic [NR-1:0] exp_gnt;
    slot   = m_t % SD;
    idx    = m_t / SD;
    exp_an = 8'hFF;
    if (slot >= GC && m_own >= 0 && !m_blank[idx]) exp_an = ~(8'd1 << idx);
    exp_seg = (exp_an == 8'hFF) ? 8'hFF : gvec[m_dig[4*idx +: 4]].seg;
    exp_gnt = (m_own < 0) ? '0 : NR'(1 << m_own);
    check("AN", an, exp_an);
    check("SEG", seg_act, exp_seg);
    check("GNT", gnt, exp_gnt);
    check("TICK", frame_tick, (m_t == FRAME - 1));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic run_to(input int pos);
    do step(1); while (m_t != pos);
  endtask

  // Called just after a falling edge; reset must blank the display asynchronously.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_AN", an, 8'hFF);
    check("rst_GNT", gnt, '0);
    check("rst_SEG", seg_act, 8'hFF);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  logic [NR-1:0] alt_exp[5];
  int ticks;

  initial begin
    gvec = '{'{4'h0, 8'hC0}, '{4'h1, 8'hF9}, '{4'h2, 8'hA4}, '{4'h3, 8'hB0},
             '{4'h4, 8'h99}, '{4'h5, 8'h92}, '{4'h6, 8'h82}, '{4'h7, 8'hF8},
             '{4'h8, 8'h80}, '{4'h9, 8'h90}, '{4'hA, 8'h88}, '{4'hB, 8'h83},
             '{4'hC, 8'hC6}, '{4'hD, 8'hA1}, '{4'hE, 8'h86}, '{4'hF, 8'h8E}};
    alt_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b001};
    rst = 1'b1; req = '0; digits = '0; blank = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle display: dark, no grant, tick once per 64 cycles
    ticks = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (frame_tick) ticks++;
    end
    check("idle_ticks", ticks, 3);

    // Single requester: grant at boundary, guarded scan, rightmost digit first
    req = 3'b001;
    digits[31:0] = 32'h1234_5678;
    run_to(FRAME - 1);
    step(1);
    check("grant_r0", gnt, 3'b001);
    step(2);
    check("idx0_AN", an, 8'hFE);
    check("idx0_SEG", seg_act, 8'h80);
    run_to(7 * SD + 2);
    check("idx7_AN", an, 8'h7F);
    check("idx7_SEG", seg_act, 8'hF9);

    // Glyph table, one code per frame
    for (int i = 0; i < 16; i++) begin
      digits[31:0] = {8{gvec[i].code}};
      run_to(FRAME - 1);
      step(1);
      run_to(3 * SD + 4);
      check("glyph", seg_act, gvec[i].seg);
    end

    // Mid-frame data change is invisible until the next boundary
    digits[31:0] = 32'hAAAA_AAAA;
    run_to(FRAME - 1);
    step(1);
    run_to(20);
    digits[31:0] = 32'h5555_5555;
    run_to(60);
    check("tear_old", seg_act, 8'h88);
    run_to(2);
    check("tear_new", seg_act, 8'h92);

    // Owner drops mid-frame: keeps display until boundary, then idle
    run_to(30);
    req = '0;
    run_to(FRAME - 1);
    check("drop_gnt_hold", gnt, 3'b001);
    check("drop_AN_hold", an, 8'h7F);
    step(1);
    check("drop_gnt", gnt, '0);
    check("drop_AN", an, 8'hFF);

    // Two requesters raised one cycle after reset alternate every HF frames
    do_reset();
    step(1);
    req = 3'b011;
    for (int f = 0; f < 5; f++) begin
      run_to(FRAME - 1);
      step(1);
      check("alternate", gnt, alt_exp[f]);
    end

    // Reset mid-frame at digit 4
    run_to(4 * SD + 3);
    do_reset();
    check("post_rst_AN", an, 8'hFF);
    run_to(FRAME - 1);
    step(1);
    check("post_rst_gnt", gnt, 3'b001);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(39) == 0) req = NR'($urandom);
      if ($urandom_range(9) == 0) begin
        r = $urandom_range(NR - 1);
        digits[32*r +: 32] = $urandom;
      end
      if ($urandom_range(29) == 0) blank = (NR*8)'($urandom & $urandom & $urandom);
      if (i == 1500) do_reset();
      else step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
